// File: rtl/hazard_control_if.sv
// Issue-side bus between decode and the hazard control unit:
// decode drives the request, the unit returns the handshake, stall and decoded controls.
interface hazard_control_if #(
  parameter int TYPE_WIDTH      = 4,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int STALL_CNT_WIDTH = 16
);
  logic                       issue_valid;
  logic [TYPE_WIDTH-1:0]      instruction_type;
  logic [REG_ADDR_WIDTH-1:0]  rs1;
  logic [REG_ADDR_WIDTH-1:0]  rs2;
  logic [REG_ADDR_WIDTH-1:0]  rd;
  logic                       flush;
  logic                       issue_ready;
  logic                       stall;
  logic                       is_write;
  logic                       is_immediate;
  logic                       is_branch;
  logic                       is_jump;
  logic                       is_mem_read;
  logic                       is_mem_write;
  logic [STALL_CNT_WIDTH-1:0] stall_count;

  modport master (
    output issue_valid, instruction_type, rs1, rs2, rd, flush,
    input  issue_ready, stall, is_write, is_immediate, is_branch, is_jump,
           is_mem_read, is_mem_write, stall_count
  );

  modport slave (
    input  issue_valid, instruction_type, rs1, rs2, rd, flush,
    output issue_ready, stall, is_write, is_immediate, is_branch, is_jump,
           is_mem_read, is_mem_write, stall_count
  );
endinterface

// File: rtl/hazard_control.sv
// Pipeline control unit: decodes the issuing instruction, blocks issue on RAW hazards
// against a shift-register scoreboard of in-flight writes, and supports flush.
module hazard_control #(
  parameter int TYPE_WIDTH      = 4,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int WB_LATENCY      = 3,
  parameter int STALL_CNT_WIDTH = 16
) (
  input logic             clock,
  input logic             reset_n,
  hazard_control_if.slave bus
);
  localparam logic [TYPE_WIDTH-1:0] T_R    = TYPE_WIDTH'(1);
  localparam logic [TYPE_WIDTH-1:0] T_I    = TYPE_WIDTH'(2);
  localparam logic [TYPE_WIDTH-1:0] T_IMEM = TYPE_WIDTH'(3);
  localparam logic [TYPE_WIDTH-1:0] T_S    = TYPE_WIDTH'(4);
  localparam logic [TYPE_WIDTH-1:0] T_B    = TYPE_WIDTH'(5);
  localparam logic [TYPE_WIDTH-1:0] T_U    = TYPE_WIDTH'(6);
  localparam logic [TYPE_WIDTH-1:0] T_J    = TYPE_WIDTH'(7);
  localparam logic [TYPE_WIDTH-1:0] T_R4   = TYPE_WIDTH'(8);

  typedef struct packed {
    logic wr;
    logic imm;
    logic br;
    logic jmp;
    logic mrd;
    logic mwr;
  } ctrl_t;

  ctrl_t                                      w_dec;
  ctrl_t                                      r_ctrl;
  logic                                       w_use1;
  logic                                       w_use2;
  logic [WB_LATENCY-1:0]                      w_hit;
  logic                                       w_stall;
  logic                                       w_accept;
  logic [WB_LATENCY-1:0]                      r_sb_vld;
  logic [WB_LATENCY-1:0][REG_ADDR_WIDTH-1:0]  r_sb_rd;
  logic [STALL_CNT_WIDTH-1:0]                 r_cnt;

  // Unknown encodings fall through to the all-zero default and behave as INVALID.
  always_comb begin
    w_dec  = '0;
    w_use1 = 1'b0;
    w_use2 = 1'b0;
    case (bus.instruction_type)
      T_R, T_R4: begin w_dec.wr = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; end
      T_I:       begin w_dec.wr = 1'b1; w_dec.imm = 1'b1; w_use1 = 1'b1; end
      T_IMEM:    begin w_dec.wr = 1'b1; w_dec.imm = 1'b1; w_dec.mrd = 1'b1; w_use1 = 1'b1; end
      T_S:       begin w_dec.imm = 1'b1; w_dec.mwr = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; end
      T_B:       begin w_dec.br = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; end
      T_U:       begin w_dec.wr = 1'b1; w_dec.imm = 1'b1; end
      T_J:       begin w_dec.wr = 1'b1; w_dec.jmp = 1'b1; end
      default:   ;
    endcase
  end

  for (genvar k = 0; k < WB_LATENCY; k++) begin : g_slot
    assign w_hit[k] = r_sb_vld[k] &&
                      ((w_use1 && (bus.rs1 != '0) && (bus.rs1 == r_sb_rd[k])) ||
                       (w_use2 && (bus.rs2 != '0) && (bus.rs2 == r_sb_rd[k])));
  end

  assign w_stall         = bus.issue_valid && !bus.flush && (|w_hit);
  assign bus.stall       = w_stall;
  assign bus.issue_ready = !w_stall && !bus.flush;
  assign w_accept        = bus.issue_valid && !w_stall && !bus.flush;

  // Slots keep shifting while stalled so the producer retires on schedule.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sb_vld <= '0;
      r_sb_rd  <= '0;
      r_ctrl   <= '0;
      r_cnt    <= '0;
    end else begin
      r_ctrl <= w_accept ? w_dec : ctrl_t'('0);
      if (w_stall && (r_cnt != '1))
        r_cnt <= r_cnt + STALL_CNT_WIDTH'(1);
      for (int k = WB_LATENCY - 1; k > 0; k--) begin
        r_sb_vld[k] <= r_sb_vld[k-1] && !bus.flush;
        r_sb_rd[k]  <= r_sb_rd[k-1];
      end
      r_sb_vld[0] <= w_accept && w_dec.wr && (bus.rd != '0);
      r_sb_rd[0]  <= bus.rd;
    end
  end

  assign bus.is_write     = r_ctrl.wr;
  assign bus.is_immediate = r_ctrl.imm;
  assign bus.is_branch    = r_ctrl.br;
  assign bus.is_jump      = r_ctrl.jmp;
  assign bus.is_mem_read  = r_ctrl.mrd;
  assign bus.is_mem_write = r_ctrl.mwr;
  assign bus.stall_count  = r_cnt;

endmodule
